// File: rtl/led_seq_pkg.sv
// Shared types for the LED sequencer: pattern modes, bounce direction and
// the divider counter width helper.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_ROL    = 2'b00,
        MODE_ROR    = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // A divide-by-one counter still needs one bit to exist.
    function automatic int cnt_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/led_sequencer_tick_div.sv
// tick_div: free-running divide-by-DIV counter; adv is high on the terminal
// count cycle while enabled.
module tick_div
    import led_seq_pkg::*;
#(
    parameter int DIV = 12000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic adv
);

    localparam int            CW   = cnt_w(DIV);
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_term;

    assign w_term = (r_cnt == TERM);
    assign adv    = en & w_term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (en)
            r_cnt <= w_term ? '0 : r_cnt + CW'(1);
    end

endmodule

// File: rtl/led_sequencer.sv
// One-hot LED pattern sequencer: rotate left/right, bounce or hold, advanced
// by a clock divider or a manual step. Bounce exists only with LED_SEQ_BOUNCE_EN.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV   = 12000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             step,
    output logic [WIDTH-1:0] leds,
    output logic             tick
);

    logic             w_adv_div;
    logic             w_adv;
    mode_e            w_mode;
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_ror;
    logic [WIDTH-1:0] w_leds_nxt;
    logic [WIDTH-1:0] r_leds;
    logic             r_tick;
`ifdef LED_SEQ_BOUNCE_EN
    dir_e             r_dir;
    dir_e             w_dir_nxt;
`endif

    tick_div #(.DIV(DIV)) u_tick_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .adv   (w_adv_div)
    );

    // Step only matters while frozen, so it can never double an advance.
    assign w_adv  = w_adv_div | (~en & step);
    assign w_mode = mode_e'(mode);

    // A single LED rotates onto itself, which keeps leds at 1 in every mode.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_rol = r_leds;
            assign w_ror = r_leds;
        end else begin : g_wn
            assign w_rol = {r_leds[WIDTH-2:0], r_leds[WIDTH-1]};
            assign w_ror = {r_leds[0], r_leds[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        w_leds_nxt = r_leds;
`ifdef LED_SEQ_BOUNCE_EN
        w_dir_nxt  = r_dir;
`endif
        if (w_adv) begin
            case (w_mode)
                MODE_ROL: w_leds_nxt = w_rol;
                MODE_ROR: w_leds_nxt = w_ror;
`ifdef LED_SEQ_BOUNCE_EN
                // Away from an end, a rotate is the same as a non-wrapping shift.
                MODE_BOUNCE: begin
                    if (r_dir == DIR_UP) begin
                        if (r_leds[WIDTH-1]) begin
                            w_dir_nxt  = DIR_DOWN;
                            w_leds_nxt = w_ror;
                        end else begin
                            w_leds_nxt = w_rol;
                        end
                    end else begin
                        if (r_leds[0]) begin
                            w_dir_nxt  = DIR_UP;
                            w_leds_nxt = w_rol;
                        end else begin
                            w_leds_nxt = w_ror;
                        end
                    end
                end
`endif
                default: w_leds_nxt = r_leds;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_leds <= WIDTH'(1);
            r_tick <= 1'b0;
`ifdef LED_SEQ_BOUNCE_EN
            r_dir  <= DIR_UP;
`endif
        end else begin
            r_leds <= w_leds_nxt;
            r_tick <= w_adv;
`ifdef LED_SEQ_BOUNCE_EN
            r_dir  <= w_dir_nxt;
`endif
        end
    end

    assign leds = r_leds;
    assign tick = r_tick;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: WIDTH=4/DIV=3 main instance plus a
// WIDTH=1/DIV=1 corner instance; bounce expectations follow LED_SEQ_BOUNCE_EN.
module tb_led_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, en, step;
    logic [1:0] mode;
    logic [3:0] leds;
    logic       tick;

    logic       rst2_n, en2, step2;
    logic [1:0] mode2;
    logic [0:0] leds2;
    logic       tick2;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] bseq [9] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100,
                             4'b0010, 4'b0001, 4'b0010, 4'b0100};

    always #5 clk = ~clk;

    led_sequencer #(.WIDTH(4), .DIV(3)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .step  (step),
        .leds  (leds),
        .tick  (tick)
    );

    led_sequencer #(.WIDTH(1), .DIV(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst2_n),
        .en    (en2),
        .mode  (mode2),
        .step  (step2),
        .leds  (leds2),
        .tick  (tick2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] rol4(input logic [3:0] v, input int n);
        logic [3:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[2:0], r[3]};
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; step = 1'b0; mode = 2'b00;
        rst2_n = 1'b0; en2 = 1'b1; step2 = 1'b0; mode2 = 2'b00;
        #12;
        chk("rst_leds", 32'(leds), 32'h1);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_leds_w1", 32'(leds2), 32'h1);
        chk("rst_tick_w1", 32'(tick2), 32'h0);

        // Rotate left from reset.
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1; mode = 2'b00;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("rol_leds", 32'(leds), 32'(rol4(4'b0001, k / 3)));
            chk("rol_tick", 32'(tick), 32'((k % 3) == 0));
        end

        // Bounce (or hold when bounce is compiled out).
        mode = 2'b10;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
`ifdef LED_SEQ_BOUNCE_EN
            chk("bnc_leds", 32'(leds), 32'(bseq[k / 3]));
`else
            chk("bnc_leds", 32'(leds), 32'h1);
`endif
            chk("bnc_tick", 32'(tick), 32'((k % 3) == 0));
        end

        // Frozen counter with manual steps, rotate right.
        rst_n = 1'b0;
        #1 chk("rst2_leds", 32'(leds), 32'h1);
        @(negedge clk);
        rst_n = 1'b1; en = 1'b0; mode = 2'b01;
        repeat (2) @(negedge clk);
        chk("frz_leds", 32'(leds), 32'h1);
        chk("frz_tick", 32'(tick), 32'h0);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        chk("step1_leds", 32'(leds), 32'h8);
        chk("step1_tick", 32'(tick), 32'h1);
        @(negedge clk);
        chk("step_tick_low", 32'(tick), 32'h0);
        chk("step_hold_leds", 32'(leds), 32'h8);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        chk("step2_leds", 32'(leds), 32'h4);
        chk("step2_tick", 32'(tick), 32'h1);
        en = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("cnt_kept_leds", 32'(leds), (k == 3) ? 32'h2 : 32'h4);
            chk("cnt_kept_tick", 32'(tick), 32'(k == 3));
        end

        // Step held while running: one advance per period.
        mode = 2'b00; step = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk("stepen_leds", 32'(leds), 32'(rol4(4'b0010, k / 3)));
            chk("stepen_tick", 32'(tick), 32'((k % 3) == 0));
        end
        step = 1'b0;

        // Asynchronous reset mid-period while tick is high.
        repeat (4) @(negedge clk);
        chk("pre_leds", 32'(leds), 32'h2);
        en = 1'b0; step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        chk("pre_rst_leds", 32'(leds), 32'h4);
        chk("pre_rst_tick", 32'(tick), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_leds", 32'(leds), 32'h1);
        chk("arst_tick", 32'(tick), 32'h0);
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1; mode = 2'b00;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("post_rst_leds", 32'(leds), (k == 3) ? 32'h2 : 32'h1);
            chk("post_rst_tick", 32'(tick), 32'(k == 3));
        end

        // Mode is sampled only at the advance; hold still ticks.
        mode = 2'b01;
        repeat (2) @(negedge clk);
        mode = 2'b11;
        @(negedge clk);
        chk("hold_leds", 32'(leds), 32'h2);
        chk("hold_tick", 32'(tick), 32'h1);
        repeat (2) @(negedge clk);
        mode = 2'b00;
        @(negedge clk);
        chk("late_rol_leds", 32'(leds), 32'h4);
        chk("late_rol_tick", 32'(tick), 32'h1);

        // WIDTH=1, DIV=1 corner.
        rst2_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            mode2 = 2'(k);
            @(negedge clk);
            chk("w1_leds", 32'(leds2), 32'h1);
            chk("w1_tick", 32'(tick2), 32'h1);
        end
        en2 = 1'b0;
        @(negedge clk);
        chk("w1_off_tick", 32'(tick2), 32'h0);
        step2 = 1'b1;
        @(negedge clk);
        step2 = 1'b0;
        chk("w1_step_tick", 32'(tick2), 32'h1);
        chk("w1_step_leds", 32'(leds2), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameter WIDTH, default 4: number of LED outputs; SHALL be >= 1.
REQ-002 Parameter DIV, default 12000000: clock cycles per pattern advance; SHALL be >= 1.
REQ-003 Port clk, input, 1: sole clock; all state on rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port en, input, 1: 1 = free-run, 0 = counter and pattern frozen.
REQ-006 Port mode, input, 2: 00 rotate-left, 01 rotate-right, 10 bounce, 11 hold.
REQ-007 Port step, input, 1: single-step request; honoured only while en=0.
REQ-008 Port leds, output, WIDTH: registered one-hot LED pattern.
REQ-009 Port tick, output, 1: registered one-cycle pulse, high in the cycle after each advance event.

Function
REQ-010 Divider counter, width max(1, $clog2(DIV)), SHALL increment each cycle en=1 and hold when en=0.
REQ-011 When en=1 and counter == DIV-1, counter SHALL return to 0 and an advance event SHALL occur; period exactly DIV cycles; DIV=1 advances every cycle.
REQ-012 When en=0 and step=1, an advance event SHALL occur that cycle; counter unchanged.
REQ-013 When en=1, step SHALL be ignored; terminal count plus step in the same cycle yields exactly one advance.
REQ-014 Rotate-left advance: leds <= {leds[WIDTH-2:0], leds[WIDTH-1]} (bit0 moves to bit1, MSB wraps to bit0).
REQ-015 Rotate-right advance: leds <= {leds[0], leds[WIDTH-1:1]} (LSB wraps to MSB).
REQ-016 Bounce SHALL use a direction register dir (UP/DOWN): UP shifts left without wrap; on advance with leds[WIDTH-1]=1 and dir=UP, dir <= DOWN and shift right; symmetric at leds[0] with dir=DOWN.
REQ-017 Entering bounce SHALL use the retained dir; if the lit bit is already at the end faced by dir, REQ-016 turnaround applies on the first advance.
REQ-018 Hold: advance events SHALL pulse tick but leave leds and dir unchanged.
REQ-019 mode SHALL be sampled only at the advance event; changes between events have no effect.
REQ-020 WIDTH=1: leds constant 1 in all modes; tick still pulses.
REQ-021 leds SHALL remain one-hot at all times after reset.
REQ-022 tick SHALL be high for exactly one cycle per advance event, including hold mode and step advances.

Reset
REQ-023 rst_n low SHALL immediately force leds=1 (bit0 lit), counter=0, dir=UP, tick=0, regardless of clk.
REQ-024 Reset asserted mid-period SHALL discard the partial count; first advance after release occurs DIV cycles after the first edge with en=1.

Configuration
REQ-025 Macro LED_SEQ_BOUNCE_EN defined: mode 10 is bounce per REQ-016/017.
REQ-026 Macro undefined: dir register SHALL not exist and mode 10 SHALL behave identically to hold (11).

Structure
REQ-027 Package led_seq_pkg SHALL hold the mode enum (MODE_ROL, MODE_ROR, MODE_BOUNCE, MODE_HOLD) and the dir enum (DIR_UP, DIR_DOWN).
REQ-028 Sub-module tick_div (parameter DIV; ports clk, rst_n, en, adv) SHALL implement REQ-010/011; led_sequencer instantiates it once.

Verification (WIDTH=4, DIV=3 unless stated)
REQ-029 Reset release, en=1, mode=00 -> leds 0001, 0010, 0100, 1000, 0001 at 3-cycle spacing; tick pulses once per change.
REQ-030 mode=10 with macro, en=1 -> leds 0001,0010,0100,1000,0100,0010,0001,0010; without macro -> leds stays 0001, tick still pulses every 3 cycles.
REQ-031 en=0, two step pulses, mode=01 -> leds 0001 -> 1000 -> 0100, one tick per step; counter unchanged.
REQ-032 en=1, step=1 held across terminal count -> exactly one advance and one tick per 3 cycles.
REQ-033 rst_n pulsed low mid-period with leds=0100 -> leds=0001 and tick=0 asynchronously; next advance exactly 3 cycles after release.
REQ-034 DIV=1, WIDTH=1 -> leds constant 1, tick high every cycle after the first.
